// File: rtl/counter_sched_pkg.sv
// counter_sched_pkg: shared FSM state type and round-robin helpers for counter_rr_scheduler
// Contents: state_t (IDLE/COUNT/DONE), rr_pick (req, ptr, n) -> index, onehot (index) -> vector
package counter_sched_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, DONE = 2'd2} state_t;
    localparam int MAX_REQ = 8;
    localparam int PTR_W = 3;
    // First set bit at or after ptr, wrapping at n; searched from the far end so the nearest wins.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req, input logic [PTR_W-1:0] ptr, input int n);
        int j;
        rr_pick = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                j = int'(ptr) + k;
                if (j >= n) j = j - n;
                if (req[j]) rr_pick = j[PTR_W-1:0];
            end
        end
    endfunction
    function automatic logic [MAX_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        return MAX_REQ'(1) << idx;
    endfunction
endpackage

// File: rtl/counter_rr_scheduler_arb.sv
// rr_arbiter_comb: combinational round-robin pick over req starting at ptr
// Ports: req, ptr in; valid (any request), idx (winner) out
module rr_arbiter_comb
    import counter_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);
    assign valid = |req;
    assign idx = IDX_W'(rr_pick(MAX_REQ'(req), PTR_W'(ptr), NUM_REQ));
endmodule

// File: rtl/counter_rr_scheduler.sv
// counter_rr_scheduler: one WIDTH-bit up-counter shared round-robin between NUM_REQ requesters
// Ports: clk, reset (sync, active-low), req, target (packed per requester) in;
//        gnt (one-hot), gnt_idx, done (one-cycle pulse), count, busy out
module counter_rr_scheduler
    import counter_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH = 8,
    parameter int IDX_W = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] target,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [IDX_W-1:0]         gnt_idx,
    output logic [NUM_REQ-1:0]       done,
    output logic [WIDTH-1:0]         count,
    output logic                     busy
);
    state_t state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n, idx_n, arb_idx;
    logic [WIDTH-1:0] tgt_q, tgt_n, count_n;
    logic [NUM_REQ-1:0] gnt_n, done_n;
    logic arb_valid;

    rr_arbiter_comb #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req  (req),
        .ptr  (ptr),
        .valid(arb_valid),
        .idx  (arb_idx)
    );

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        idx_n   = gnt_idx;
        tgt_n   = tgt_q;
        gnt_n   = gnt;
        done_n  = '0;
        count_n = count;
        case (state)
            IDLE: if (arb_valid) begin
                state_n = COUNT;
                gnt_n   = NUM_REQ'(onehot(PTR_W'(arb_idx)));
                idx_n   = arb_idx;
                tgt_n   = target[int'(arb_idx)*WIDTH +: WIDTH];
                count_n = '0;
                ptr_n   = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
            end
            // A dropped request wins over reaching the target: abort without done.
            COUNT: if (!req[gnt_idx]) begin
                state_n = IDLE;
                gnt_n   = '0;
                count_n = '0;
            end else if (count == tgt_q) begin
                state_n = DONE;
                done_n  = gnt;
            end else begin
                count_n = count + 1'b1;
            end
            DONE: begin
                state_n = IDLE;
                gnt_n   = '0;
                count_n = '0;
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                count_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt_idx <= '0;
            tgt_q   <= '0;
            gnt     <= '0;
            done    <= '0;
            count   <= '0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            gnt_idx <= idx_n;
            tgt_q   <= tgt_n;
            gnt     <= gnt_n;
            done    <= done_n;
            count   <= count_n;
        end
    end

    assign busy = (state != IDLE);
endmodule
